// File: rtl/rpsc_pkg.sv
// rtl/rpsc_pkg.sv - shared channel count, index type and state encoding for the fault sequencer
package rpsc_pkg;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;

    typedef logic [2:0] ch_idx_t;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_TRIPPED  = 2'd1,
        ST_CLEARING = 2'd2
    } state_t;

    // Lowest set bit wins, so scan from the top and let lower hits overwrite.
    function automatic ch_idx_t lowest_set(input logic [NUM_CH-1:0] v);
        ch_idx_t idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ch_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rpsc_debounce.sv
// rtl/rpsc_debounce.sv - one fault channel: 2-flop synchronizer followed by a symmetric debounce counter
module rpsc_debounce
    import rpsc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Counter measures how long the synced input has disagreed with the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rpsc_fault_sequencer.sv
// rtl/rpsc_fault_sequencer.sv - debounced fault latching and trip/clear sequencing; RPSC_FIRST_OUT_EN adds first-out capture
module rpsc_fault_sequencer
    import rpsc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] fault_in,
    input  logic       clear_req,
    output logic [7:0] fault_out,
    output logic [7:0] fault_la,
    output logic       trip,
    output logic [2:0] first_out,
    output logic       first_valid,
    output logic       clear_fail
);

    state_t            state;
    state_t            state_next;
    logic [NUM_CH-1:0] la_next;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        rpsc_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (fault_in[i]),
            .level (fault_out[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_NORMAL;
        end else begin
            state <= state_next;
        end
    end

    // Latches are empty in NORMAL, so any live fault there is a fresh trip.
    always_comb begin
        state_next = state;
        la_next    = fault_la | fault_out;
        case (state)
            ST_NORMAL: begin
                if (|fault_out) begin
                    state_next = ST_TRIPPED;
                end
            end
            ST_TRIPPED: begin
                if (clear_req) begin
                    state_next = ST_CLEARING;
                end
            end
            ST_CLEARING: begin
                la_next    = (fault_la & fault_out) | fault_out;
                state_next = (|la_next) ? ST_TRIPPED : ST_NORMAL;
            end
            default: begin
                state_next = ST_NORMAL;
            end
        endcase
    end

    always_comb begin
        trip = (state != ST_NORMAL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_la   <= '0;
            clear_fail <= 1'b0;
        end else begin
            fault_la   <= la_next;
            clear_fail <= (state == ST_CLEARING) && (|la_next);
        end
    end

`ifdef RPSC_FIRST_OUT_EN
    ch_idx_t first_q;
    logic    first_v_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            first_q   <= '0;
            first_v_q <= 1'b0;
        end else if (state == ST_NORMAL && state_next == ST_TRIPPED) begin
            first_q   <= lowest_set(fault_out);
            first_v_q <= 1'b1;
        end else if (state != ST_NORMAL && state_next == ST_NORMAL) begin
            first_q   <= '0;
            first_v_q <= 1'b0;
        end
    end

    assign first_out   = first_q;
    assign first_valid = first_v_q;
`else
    assign first_out   = 3'd0;
    assign first_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rpsc_fault_sequencer.sv
// tb/tb_rpsc_fault_sequencer.sv - vector table, hand sequences and randomized run against a behavioural model
module tb_rpsc_fault_sequencer;

    localparam int D = 16;

    logic       clk;
    logic       reset;
    logic [7:0] fault_in;
    logic       clear_req;
    logic [7:0] fault_out;
    logic [7:0] fault_la;
    logic       trip;
    logic [2:0] first_out;
    logic       first_valid;
    logic       clear_fail;

    int checks = 0;
    int errors = 0;

    rpsc_fault_sequencer #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fault_in    (fault_in),
        .clear_req   (clear_req),
        .fault_out   (fault_out),
        .fault_la    (fault_la),
        .trip        (trip),
        .first_out   (first_out),
        .first_valid (first_valid),
        .clear_fail  (clear_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] fi;
        logic       cr;
        int         n;
        logic [7:0] out;
        logic [7:0] la;
        logic       trip;
        logic [2:0] fo;
        logic       fv;
        logic       cf;
    } vec_t;

    vec_t tbl[$];

    // Reference model: history of raw samples, one entry per edge, newest first.
    logic [7:0] hist[$];
    logic [7:0] m_out;
    logic [7:0] m_la;
    logic       m_tripped;
    logic       m_clearing;
    logic       m_cf;
    logic [2:0] m_fo;
    logic       m_fv;

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back(8'h00);
        m_out = 8'h00;
        m_la = 8'h00;
        m_tripped = 1'b0;
        m_clearing = 1'b0;
        m_cf = 1'b0;
        m_fo = 3'd0;
        m_fv = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] out_old;
        logic [7:0] la_new;
        bit         disagree;
        if (reset) begin
            model_reset();
            return;
        end
        out_old = m_out;
        hist.push_front(fault_in);
        void'(hist.pop_back());
        // A channel flips once its input, seen two edges late, has disagreed for D edges running.
        for (int i = 0; i < 8; i++) begin
            disagree = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (hist[2 + k][i] == out_old[i]) disagree = 1'b0;
            end
            if (disagree) m_out[i] = ~out_old[i];
        end
        la_new = m_clearing ? out_old : (m_la | out_old);
        m_cf = 1'b0;
        if (m_clearing) begin
            m_clearing = 1'b0;
            m_tripped = (la_new != 8'h00);
            m_cf = (la_new != 8'h00);
            if (la_new == 8'h00) begin
                m_fo = 3'd0;
                m_fv = 1'b0;
            end
        end else if (m_tripped) begin
            if (clear_req) m_clearing = 1'b1;
        end else if (la_new != 8'h00) begin
            m_tripped = 1'b1;
            m_fv = 1'b1;
            for (int i = 7; i >= 0; i--) begin
                if (la_new[i]) m_fo = 3'(i);
            end
        end
        m_la = la_new;
    endtask

    task automatic check_model();
        logic [2:0] efo;
        logic       efv;
        logic [21:0] got;
        logic [21:0] exp;
`ifdef RPSC_FIRST_OUT_EN
        efo = m_fo;
        efv = m_fv;
`else
        efo = 3'd0;
        efv = 1'b0;
`endif
        got = {fault_out, fault_la, trip, first_out, first_valid, clear_fail};
        exp = {m_out, m_la, (m_tripped | m_clearing), efo, efv, m_cf};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL model t=%0t got out/la/trip/fo/fv/cf=%h/%h/%b/%0d/%b/%b required %h/%h/%b/%0d/%b/%b",
                     $time, fault_out, fault_la, trip, first_out, first_valid, clear_fail,
                     exp[21:14], exp[13:6], exp[5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic check_const(input string name, input vec_t v);
        logic [2:0] efo;
        logic       efv;
`ifdef RPSC_FIRST_OUT_EN
        efo = v.fo;
        efv = v.fv;
`else
        efo = 3'd0;
        efv = 1'b0;
`endif
        checks++;
        if ({fault_out, fault_la, trip, first_out, first_valid, clear_fail} !==
            {v.out, v.la, v.trip, efo, efv, v.cf}) begin
            errors++;
            $display("FAIL %s got out/la/trip/fo/fv/cf=%h/%h/%b/%0d/%b/%b required %h/%h/%b/%0d/%b/%b",
                     name, fault_out, fault_la, trip, first_out, first_valid, clear_fail,
                     v.out, v.la, v.trip, efo, efv, v.cf);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        vec_t zero_v;
        zero_v = '{8'h00, 1'b0, 0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};

        // rise latency, failed clear, fall latency, successful clear
        tbl.push_back('{8'h04, 1'b0, 17, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{8'h04, 1'b0,  1, 8'h04, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{8'h04, 1'b0,  1, 8'h04, 8'h04, 1'b1, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{8'h04, 1'b1,  1, 8'h04, 8'h04, 1'b1, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{8'h04, 1'b0,  1, 8'h04, 8'h04, 1'b1, 3'd2, 1'b1, 1'b1});
        tbl.push_back('{8'h04, 1'b0,  1, 8'h04, 8'h04, 1'b1, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b0, 17, 8'h04, 8'h04, 1'b1, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b0,  1, 8'h00, 8'h04, 1'b1, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b1,  1, 8'h00, 8'h04, 1'b1, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b0,  1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0});
        // glitch rejection, clear_req ignored in NORMAL
        tbl.push_back('{8'h20, 1'b0, 10, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{8'h00, 1'b1, 30, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0});
        // simultaneous faults
        tbl.push_back('{8'h48, 1'b0, 18, 8'h48, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{8'h48, 1'b0,  1, 8'h48, 8'h48, 1'b1, 3'd3, 1'b1, 1'b0});
        tbl.push_back('{8'h08, 1'b0, 18, 8'h08, 8'h48, 1'b1, 3'd3, 1'b1, 1'b0});
        tbl.push_back('{8'h00, 1'b0, 18, 8'h00, 8'h48, 1'b1, 3'd3, 1'b1, 1'b0});
        // new fault rises on the edge into CLEARING; clear_req in CLEARING is dropped
        tbl.push_back('{8'h01, 1'b0, 17, 8'h00, 8'h48, 1'b1, 3'd3, 1'b1, 1'b0});
        tbl.push_back('{8'h01, 1'b1,  1, 8'h01, 8'h48, 1'b1, 3'd3, 1'b1, 1'b0});
        tbl.push_back('{8'h01, 1'b1,  1, 8'h01, 8'h01, 1'b1, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{8'h01, 1'b0,  1, 8'h01, 8'h01, 1'b1, 3'd3, 1'b1, 1'b0});
        // all channels faulted ahead of the reset sequence
        tbl.push_back('{8'hFF, 1'b0, 19, 8'hFF, 8'hFF, 1'b1, 3'd3, 1'b1, 1'b0});

        fault_in = 8'h00;
        clear_req = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        reset = 1'b1;
        #2;
        check_const("reset_state", zero_v);
        tick();
        tick();
        reset = 1'b0;

        for (int v = 0; v < tbl.size(); v++) begin
            fault_in = tbl[v].fi;
            clear_req = tbl[v].cr;
            for (int c = 0; c < tbl[v].n; c++) begin
                tick();
                clear_req = 1'b0;
            end
            check_const($sformatf("vec%0d", v), tbl[v]);
        end

        // async reset while tripped with every fault present, then re-qualification
        reset = 1'b1;
        model_reset();
        #1;
        check_const("async_reset", zero_v);
        check_model();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 17; c++) tick();
        check_const("requalify_17", zero_v);
        tick();
        check_const("requalify_18", '{8'hFF, 1'b0, 0, 8'hFF, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0});

        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(39) == 0) fault_in[i] = ~fault_in[i];
            end
            clear_req = ($urandom_range(7) == 0);
            if ($urandom_range(599) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_model();
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
